// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8-bit frame
// with odd parity, device ACK check and line-release wait.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1200,
  parameter int TIMEOUT_CYCLES = 180000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       send,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
                        TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_XFER    = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [9:0]    r_shift;
  logic          r_ck_s1, r_ck_s2, r_ck_s3;
  logic          r_dt_s1, r_dt_s2;
  logic          r_clk_oe, r_dat_oe;
  logic          r_busy, r_done, r_error;

  logic w_fall;
  logic w_wait;
  logic w_rel_ok;
  logic w_to;
  logic w_nack;
  logic w_fail;

  assign w_fall   = r_ck_s3 & ~r_ck_s2;
  assign w_rel_ok = r_ck_s2 & r_dt_s2;
  assign w_wait   = (r_state == S_XFER) || (r_state == S_ACK) ||
                    ((r_state == S_RELEASE) && !w_rel_ok);
  assign w_to     = w_wait && !w_fall && (r_cnt == TO_LAST);
  assign w_nack   = (r_state == S_ACK) && w_fall && r_dt_s2;
  assign w_fail   = w_to | w_nack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_ck_s1  <= 1'b1;
      r_ck_s2  <= 1'b1;
      r_ck_s3  <= 1'b1;
      r_dt_s1  <= 1'b1;
      r_dt_s2  <= 1'b1;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_ck_s1 <= ps2clk_in;
      r_ck_s2 <= r_ck_s1;
      r_ck_s3 <= r_ck_s2;
      r_dt_s1 <= ps2data_in;
      r_dt_s2 <= r_dt_s1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (send) begin
            r_shift  <= {1'b1, ~^data_in, data_in};
            r_busy   <= 1'b1;
            r_clk_oe <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_cnt == INH_LAST) begin
            r_dat_oe <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_START;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_START: begin
          r_clk_oe <= 1'b0;
          r_bit    <= '0;
          r_cnt    <= '0;
          r_state  <= S_XFER;
        end
        S_XFER: begin
          r_cnt <= w_fall ? '0 : r_cnt + 1'b1;
          if (w_fall) begin
            // LSB-first shift; the stop bit (1) releases the line
            r_dat_oe <= ~r_shift[0];
            r_shift  <= r_shift >> 1;
            r_bit    <= r_bit + 4'd1;
            if (r_bit == 4'd9) r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_cnt <= w_fall ? '0 : r_cnt + 1'b1;
          if (w_fall && !r_dt_s2) begin
            r_cnt   <= '0;
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_cnt <= w_fall ? '0 : r_cnt + 1'b1;
          if (w_rel_ok) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_fail) begin
        r_error  <= 1'b1;
        r_busy   <= 1'b0;
        r_clk_oe <= 1'b0;
        r_dat_oe <= 1'b0;
        r_cnt    <= '0;
        r_state  <= S_IDLE;
      end
    end
  end

  assign ps2clk_oe  = r_clk_oe;
  assign ps2data_oe = r_dat_oe;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam int INH  = 1200;
  localparam int TO   = 4000;
  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2clk_oe, ps2data_oe, busy, done, error;
  logic       line_clk, line_dat;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  assign line_clk = dev_clk & ~ps2clk_oe;
  assign line_dat = dev_dat & ~ps2data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .send       (send),
    .ps2clk_in  (line_clk),
    .ps2data_in (line_dat),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("pulse_in_rst", 32'({done, error}), 0);
    end else if (done || error) begin
      if (done) done_cnt++;
      if (error) begin
        err_cnt++;
        chk("err_oe_rel", 32'({ps2clk_oe, ps2data_oe}), 0);
      end
      chk("done_and_err", 32'(done & error), 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_send(input logic [7:0] b);
    cyc(1);
    data_in = b;
    send = 1'b1;
    cyc(1);
    send = 1'b0;
  endtask

  task automatic device(input int nedges, input bit ack,
                        output logic [9:0] bits);
    bit ok = 0;
    bits = '0;
    for (int i = 0; i < INH + 100; i++) begin
      @(negedge clk);
      if (ps2data_oe && !ps2clk_oe) begin
        ok = 1;
        break;
      end
    end
    chk("start_seen", 32'(ok), 1);
    cyc(HALF);
    for (int i = 1; i <= nedges; i++) begin
      if (i == 11 && ack) dev_dat = 1'b0;
      dev_clk = 1'b0;
      cyc(HALF);
      dev_clk = 1'b1;
      if (i <= 10) bits[i-1] = line_dat;
      cyc(HALF);
      dev_dat = 1'b1;
    end
  endtask

  logic [9:0] bits;
  int d0, e0, n;
  bit seen;

  initial begin
    cyc(3);
    chk("rst_clk_oe", 32'(ps2clk_oe), 0);
    chk("rst_dat_oe", 32'(ps2data_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    rst = 1'b0;
    cyc(2);

    // 0xF4 with ACK
    d0 = done_cnt; e0 = err_cnt;
    pulse_send(8'hF4);
    chk("busy_on_send", 32'(busy), 1);
    device(11, 1'b1, bits);
    cyc(20);
    chk("frame_F4", 32'(bits), 32'h2F4);
    chk("done_F4", 32'(done_cnt - d0), 1);
    chk("noerr_F4", 32'(err_cnt - e0), 0);
    chk("busy_F4", 32'(busy), 0);

    // 0xED: inhibit length and parity 1
    d0 = done_cnt;
    pulse_send(8'hED);
    n = 0;
    for (int i = 0; i < INH + 50; i++) begin
      @(negedge clk);
      if (ps2data_oe) break;
      if (ps2clk_oe) n++;
    end
    chk("inhibit_len", 32'(n), INH);
    device(11, 1'b1, bits);
    cyc(20);
    chk("frame_ED", 32'(bits), 32'h3ED);
    chk("done_ED", 32'(done_cnt - d0), 1);

    // no ACK from device
    d0 = done_cnt; e0 = err_cnt;
    pulse_send(8'h3C);
    device(11, 1'b0, bits);
    cyc(20);
    chk("frame_3C", 32'(bits), 32'h33C);
    chk("nack_err", 32'(err_cnt - e0), 1);
    chk("nack_done", 32'(done_cnt - d0), 0);
    chk("nack_oe", 32'({ps2clk_oe, ps2data_oe}), 0);
    chk("nack_busy", 32'(busy), 0);

    // device never clocks
    d0 = done_cnt; e0 = err_cnt;
    pulse_send(8'h01);
    seen = 0;
    for (int i = 0; i < INH + 100; i++) begin
      @(negedge clk);
      if (busy && !ps2clk_oe && ps2data_oe) begin
        seen = 1;
        break;
      end
    end
    chk("to_start", 32'(seen), 1);
    n = 0;
    for (int i = 0; i < TO + 100; i++) begin
      if (error) break;
      n++;
      @(negedge clk);
    end
    chk("timeout_len", 32'(n), TO);
    chk("to_busy", 32'(busy), 0);
    chk("to_oe", 32'({ps2clk_oe, ps2data_oe}), 0);
    cyc(2);
    chk("to_err", 32'(err_cnt - e0), 1);
    chk("to_done", 32'(done_cnt - d0), 0);

    // reset mid-transfer, then a clean 0x55
    pulse_send(8'h81);
    device(4, 1'b1, bits);
    rst = 1'b1;
    cyc(1);
    chk("abort_oe", 32'({ps2clk_oe, ps2data_oe}), 0);
    chk("abort_busy", 32'(busy), 0);
    rst = 1'b0;
    cyc(2);
    d0 = done_cnt;
    pulse_send(8'h55);
    device(11, 1'b1, bits);
    cyc(20);
    chk("frame_55", 32'(bits), 32'h355);
    chk("done_55", 32'(done_cnt - d0), 1);

    // second send during transfer is ignored
    d0 = done_cnt;
    pulse_send(8'hAA);
    fork
      device(11, 1'b1, bits);
      begin
        cyc(INH + HALF * 6);
        data_in = 8'h00;
        send = 1'b1;
        cyc(1);
        send = 1'b0;
      end
    join
    cyc(20);
    chk("frame_AA", 32'(bits), 32'h3AA);
    chk("done_AA", 32'(done_cnt - d0), 1);
    chk("idle_AA", 32'({busy, ps2clk_oe, ps2data_oe}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
